return_accum: RTL

- Downstream stage of the POMDP simulation step generator. It consumes that generator's (out_reward, new_state, en_calculate) outputs.
- Runs one rollout of a programmable horizon. Per step, it issues the generator's one-cycle `en` and feeds back the sampled state as the next `cur_state`.
- Accumulates the discounted return sum(gamma^k * r_k) in Q1.15 fixed point and reports it with a one-cycle done pulse.

---
 rtl/pomdp_pkg.sv | 17 +
 rtl/q15_mul.sv | 21 ++
 rtl/return_accum.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pomdp_pkg.sv
// Shared types and Q1.15 constants for the POMDP rollout datapath.
//   rollout_state_t : rollout controller states
//   Q15_ONE         : 1.0 in unsigned Q1.15
//   Q15_SHIFT       : binary point position of Q1.15
package pomdp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } rollout_state_t;

    localparam logic [15:0] Q15_ONE   = 16'h8000;
    localparam int unsigned Q15_SHIFT = 15;

endpackage

// File: rtl/q15_mul.sv
// Unsigned Q1.15 multiply: p = (a * b) >> 15, truncated to DATA_W+1 bits.
//   a, b : DATA_W-bit unsigned operands
//   p    : DATA_W+1-bit scaled product
module q15_mul
    import pomdp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   p
);

    logic [2*DATA_W-1:0] prod;

    always_comb begin
        prod = a * b;
        p    = (DATA_W+1)'(prod >> Q15_SHIFT);
    end

endmodule

// File: rtl/return_accum.sv
// Rollout controller that drives the POMDP step generator for a programmable
// horizon and accumulates the discounted return sum(gamma^k * r_k) in Q1.15.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a rollout (accepted only when idle)
//   init_state     : state for step 0
//   horizon, gamma : step count and Q1.15 discount, latched on start
//   en_calculate   : generator result valid, with in_reward / in_new_state
//   step_en        : one-cycle request to the generator
//   cur_state      : state presented to the generator
//   busy, done     : rollout in progress / one-cycle completion pulse
//   total_return   : saturated discounted return, held after done
module return_accum
    import pomdp_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int HORIZON_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 init_state,
    input  logic [HORIZON_W-1:0] horizon,
    input  logic [DATA_W-1:0]    gamma,
    input  logic                 en_calculate,
    input  logic [DATA_W-1:0]    in_reward,
    input  logic                 in_new_state,
    output logic                 step_en,
    output logic                 cur_state,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     total_return
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(Q15_ONE);

    rollout_state_t       state;
    logic [HORIZON_W-1:0] horizon_q;
    logic [HORIZON_W-1:0] step_cnt;
    logic [DATA_W-1:0]    gamma_q;
    logic [DATA_W-1:0]    weight;
    logic [ACC_W-1:0]     acc;

    logic [DATA_W:0]      reward_term;
    logic [DATA_W:0]      weight_prod;
    logic [DATA_W-1:0]    weight_next;
    logic [ACC_W:0]       acc_sum;
    logic [ACC_W-1:0]     acc_next;
    logic                 last_step;

    q15_mul #(.DATA_W(DATA_W)) u_reward_mul (
        .a (in_reward),
        .b (weight),
        .p (reward_term)
    );

    q15_mul #(.DATA_W(DATA_W)) u_weight_mul (
        .a (weight),
        .b (gamma_q),
        .p (weight_prod)
    );

    always_comb begin
        acc_sum   = {1'b0, acc} + (ACC_W+1)'(reward_term);
        acc_next  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        // gamma is clamped to 1.0, so weight never exceeds 1.0; the guard
        // only keeps the register in range should that ever be violated.
        weight_next = weight_prod[DATA_W] ? '1 : weight_prod[DATA_W-1:0];
        // Compare one bit wider so horizon = max does not wrap the counter.
        last_step = ({1'b0, step_cnt} + (HORIZON_W+1)'(1)) == {1'b0, horizon_q};
    end

    // step_en / done / busy are registered on the transition into the state
    // they belong to, so they are valid for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            step_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_state    <= 1'b0;
            total_return <= '0;
            acc          <= '0;
            weight       <= ONE;
            step_cnt     <= '0;
            horizon_q    <= '0;
            gamma_q      <= '0;
        end else begin
            step_en <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        horizon_q <= horizon;
                        gamma_q   <= (gamma > ONE) ? ONE : gamma;
                        cur_state <= init_state;
                        acc       <= '0;
                        weight    <= ONE;
                        step_cnt  <= '0;
                        if (horizon == '0) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            total_return <= '0;
                        end else begin
                            state   <= ISSUE;
                            step_en <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (en_calculate) begin
                        acc       <= acc_next;
                        weight    <= weight_next;
                        cur_state <= in_new_state;
                        step_cnt  <= step_cnt + HORIZON_W'(1);
                        if (last_step) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            total_return <= acc_next;
                        end else begin
                            state   <= ISSUE;
                            step_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
